// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline (package)
// Brief    : Inter-stage payload structs and their NOP bundles.
// Revision : 1.0 - initial release
// ============================================================================
package pipeline;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } decode_signals;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        alu_op_e     alu_op;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } execute_signals;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } memory_signals;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        reg_write;
    } writeback_signals;

    // NOP bundles have every control bit low, so a bubble never writes state.
    localparam decode_signals    DECODE_NOP    = '0;
    localparam execute_signals   EXECUTE_NOP   = '0;
    localparam memory_signals    MEMORY_NOP    = '0;
    localparam writeback_signals WRITEBACK_NOP = '0;

endpackage
`default_nettype wire

// File: rtl/elastic_stage_ptr.sv
`default_nettype none
// ============================================================================
// Module   : elastic_ptr
// Brief    : Mod-DEPTH wrap-around pointer with synchronous clear.
// Revision : 1.0 - initial release
// ============================================================================
module elastic_ptr #(
    parameter  int DEPTH = 2,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // Explicit wrap keeps non-power-of-two depths correct.
    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule
`default_nettype wire

// File: rtl/elastic_stage.sv
`default_nettype none
// ============================================================================
// Module   : elastic_stage
// Brief    : Valid/ready elastic pipeline register backed by a DEPTH-entry
//            circular buffer. Define ELASTIC_STAGE_BYPASS_EN for an empty-
//            buffer zero-latency pass-through path.
// Revision : 1.0 - initial release
// ============================================================================
module elastic_stage
    import pipeline::*;
#(
    parameter type T     = execute_signals,
    parameter int  DEPTH = 2,
    parameter T    NOP   = EXECUTE_NOP,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  T              in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output T              out_data,
    output logic [CW-1:0] count
);

    T              mem_q [DEPTH];
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [PW-1:0] w_rd_ptr;
    logic [PW-1:0] w_wr_ptr;
    logic          w_empty;
    logic          w_bypass;
    logic          w_push;
    logic          w_pop;
    logic          w_through;
    logic          w_wr;
    logic          w_rd;

    assign w_empty = (count_q == '0);

`ifdef ELASTIC_STAGE_BYPASS_EN
    assign w_bypass = w_empty & ~flush & ~reset;
`else
    assign w_bypass = 1'b0;
`endif

    // in_ready depends only on local state, never on out_ready.
    assign in_ready  = (count_q < CW'(DEPTH)) & ~reset;
    assign out_valid = ~reset & (~w_empty | (w_bypass & in_valid));
    assign out_data  = ~out_valid ? NOP : (w_empty ? in_data : mem_q[w_rd_ptr]);

    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign w_through = w_bypass & w_push & out_ready;
    assign w_wr      = w_push & ~w_through & ~flush;
    assign w_rd      = w_pop & ~w_empty & ~flush;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(w_wr) - CW'(w_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            mem_q[w_wr_ptr] <= in_data;
        end
    end

    elastic_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (flush),
        .inc   (w_rd),
        .ptr   (w_rd_ptr)
    );

    elastic_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (flush),
        .inc   (w_wr),
        .ptr   (w_wr_ptr)
    );

    assign count = count_q;

    a_no_overflow : assert property (@(posedge clk) disable iff (reset)
        count_q <= CW'(DEPTH));
    a_no_underflow : assert property (@(posedge clk) disable iff (reset)
        !(w_rd && w_empty));

endmodule
`default_nettype wire

// File: tb/tb_elastic_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_elastic_stage
// Brief    : Scoreboard bench for elastic_stage at DEPTH 2, 3 and 1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_elastic_stage;

    localparam logic [7:0] NOP8 = 8'h5A;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    // DUT a: DEPTH 2, DUT b: DEPTH 3, DUT c: DEPTH 1
    logic       a_iv = 0, a_ir, a_ov, a_or = 0, a_fl = 0;
    logic [7:0] a_id = 0, a_od;
    logic [1:0] a_cnt;
    logic       b_iv = 0, b_ir, b_ov, b_or = 0, b_fl = 0;
    logic [7:0] b_id = 0, b_od;
    logic [1:0] b_cnt;
    logic       c_iv = 0, c_ir, c_ov, c_or = 0, c_fl = 0;
    logic [7:0] c_id = 0, c_od;
    logic [0:0] c_cnt;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    logic [7:0] q_c[$];

    elastic_stage #(.T(logic [7:0]), .DEPTH(2), .NOP(NOP8)) u_a (
        .clk(clk), .reset(rst), .flush(a_fl), .in_valid(a_iv), .in_ready(a_ir),
        .in_data(a_id), .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .count(a_cnt));
    elastic_stage #(.T(logic [7:0]), .DEPTH(3), .NOP(NOP8)) u_b (
        .clk(clk), .reset(rst), .flush(b_fl), .in_valid(b_iv), .in_ready(b_ir),
        .in_data(b_id), .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .count(b_cnt));
    elastic_stage #(.T(logic [7:0]), .DEPTH(1), .NOP(NOP8)) u_c (
        .clk(clk), .reset(rst), .flush(c_fl), .in_valid(c_iv), .in_ready(c_ir),
        .in_data(c_id), .out_valid(c_ov), .out_ready(c_or), .out_data(c_od), .count(c_cnt));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitors: every accepted output is popped from its scoreboard queue.
    always @(negedge clk) begin
        if (a_ov && a_or) begin
            if (q_a.size() == 0) chk("a_unexpected_out", {24'd0, a_od}, 32'hFFFF_FFFF);
            else chk("a_out", {24'd0, a_od}, {24'd0, q_a.pop_front()});
        end
        if (b_ov && b_or) begin
            if (q_b.size() == 0) chk("b_unexpected_out", {24'd0, b_od}, 32'hFFFF_FFFF);
            else chk("b_out", {24'd0, b_od}, {24'd0, q_b.pop_front()});
        end
        if (c_ov && c_or) begin
            if (q_c.size() == 0) chk("c_unexpected_out", {24'd0, c_od}, 32'hFFFF_FFFF);
            else chk("c_out", {24'd0, c_od}, {24'd0, q_c.pop_front()});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] stream [6];
        int idx;
        int cyc;

        // Reset held for two edges
        tick;
        chk("rst_in_ready", a_ir, 0);
        chk("rst_out_valid", a_ov, 0);
        chk("rst_out_data", a_od, NOP8);
        chk("rst_count", a_cnt, 0);
        tick;
        rst = 1'b0;
        #1;
        chk("post_rst_a_ready", a_ir, 1);
        chk("post_rst_b_ready", b_ir, 1);
        chk("post_rst_c_ready", c_ir, 1);
        chk("post_rst_count", a_cnt, 0);

        // Fill then drain, DEPTH 2
        a_iv = 1; a_id = 8'h0A; q_a.push_back(8'h0A);
        tick;
        a_id = 8'h0B; q_a.push_back(8'h0B);
        tick;
        a_iv = 0;
        #1;
        chk("fill_count", a_cnt, 2);
        chk("fill_in_ready", a_ir, 0);
        chk("fill_head", a_od, 8'h0A);
        a_or = 1;
        tick;
        tick;
        chk("drain_valid", a_ov, 0);
        chk("drain_nop", a_od, NOP8);
        a_or = 0;

        // Simultaneous push/pop at count 1, DEPTH 3, wraps the pointers
        b_iv = 1; b_id = 8'h0A; q_b.push_back(8'h0A);
        tick;
        b_or = 1;
        for (int i = 0; i < 7; i++) begin
            b_id = 8'hC0 + 8'(i);
            q_b.push_back(b_id);
            tick;
            chk("pushpop_count", b_cnt, 1);
        end
        b_iv = 0;
        tick;
        chk("pushpop_final_count", b_cnt, 0);
        b_or = 0;

        // Flush at count 2 with a push offered
        a_iv = 1; a_id = 8'h11;
        tick;
        a_id = 8'h12;
        tick;
        chk("preflush_count", a_cnt, 2);
        a_id = 8'h0D; a_fl = 1;
        tick;
        a_fl = 0; a_iv = 0;
        chk("flush_count", a_cnt, 0);
        chk("flush_valid", a_ov, 0);
        // Flush at count 1 with a push that would be accepted
        a_iv = 1; a_id = 8'h13;
        tick;
        a_id = 8'h0D; a_fl = 1;
        tick;
        a_fl = 0; a_iv = 0;
        chk("flush1_count", a_cnt, 0);
        // Only this later entry may emerge
        a_iv = 1; a_id = 8'h22; q_a.push_back(8'h22);
        tick;
        a_iv = 0; a_or = 1;
        tick;
        a_or = 0;
        chk("after_flush_count", a_cnt, 0);

        // Back-pressured stream, DEPTH 1
        for (int i = 0; i < 6; i++) begin
            stream[i] = 8'h31 + 8'(i);
            q_c.push_back(stream[i]);
        end
        idx = 0;
        cyc = 0;
        c_iv = 1;
        while (idx < 6 && cyc < 40) begin
            c_id = stream[idx];
            c_or = ~cyc[0];
            #1;
            if (c_ir) begin
                tick;
                idx++;
            end else begin
                tick;
            end
            cyc++;
        end
        chk("stream_all_accepted", idx, 6);
        c_iv = 0; c_or = 1;
        tick;
        tick;
        chk("stream_all_emitted", q_c.size(), 0);
        chk("stream_count", c_cnt, 0);
        c_or = 0;

        // Empty-buffer latency
        a_iv = 1; a_id = 8'h0E; a_or = 1; q_a.push_back(8'h0E);
        #1;
`ifdef ELASTIC_STAGE_BYPASS_EN
        chk("bypass_valid", a_ov, 1);
        chk("bypass_data", a_od, 8'h0E);
        tick;
        a_iv = 0;
        chk("bypass_count", a_cnt, 0);
`else
        chk("nobypass_valid", a_ov, 0);
        tick;
        a_iv = 0;
        #1;
        chk("nobypass_count", a_cnt, 1);
        chk("nobypass_data", a_od, 8'h0E);
        tick;
        chk("nobypass_drained", a_cnt, 0);
`endif
        a_or = 0;
        tick;

        chk("q_a_empty", q_a.size(), 0);
        chk("q_b_empty", q_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire
